// File: rtl/pkg_out_sched5_if.sv
// Handshake bundle between an output-port scheduler and the router fabric:
// per-input requests/tails in, grant/select/credit status out.
interface pkg_out_sched5_if #(
  parameter int NUM_REQUESTERS = 5,
  parameter int CW             = 3
);
  logic [NUM_REQUESTERS-1:0] req;
  logic [NUM_REQUESTERS-1:0] tail;
  logic                      credit_in;
  logic                      flush;
  logic [NUM_REQUESTERS-1:0] gnt;
  logic [2:0]                out_sel;
  logic                      busy;
  logic                      fire;
  logic [CW-1:0]             credits;
  logic                      cred_err;

  modport master (
    output req, tail, credit_in, flush,
    input  gnt, out_sel, busy, fire, credits, cred_err
  );

  modport slave (
    input  req, tail, credit_in, flush,
    output gnt, out_sel, busy, fire, credits, cred_err
  );
endinterface

// File: rtl/pkg_out_sched5.sv
// Output-port packet scheduler: round-robin arbitration over 5 inputs, packet
// lock until tail (or flush), and credit-gated flit transfer.
module pkg_out_sched5 #(
  parameter int NUM_REQUESTERS = 5,
  parameter int CREDIT_MAX     = 4,
  parameter int CW             = 3
) (
  input logic               clk,
  input logic               rst,
  pkg_out_sched5_if.slave   bus
);
  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [CW-1:0] CREDIT_MAX_C = CW'(CREDIT_MAX);
  localparam logic [2:0]    LAST_IDX     = 3'(NUM_REQUESTERS - 1);

  state_t                    state_q, state_d;
  logic [NUM_REQUESTERS-1:0] gnt_q, gnt_d;
  logic [2:0]                out_sel_q, out_sel_d;
  logic [2:0]                ptr_q, ptr_d;
  logic [CW-1:0]             credits_q, credits_d;
  logic                      cred_err_q, cred_err_d;

  logic                        owner_req;
  logic                        owner_tail;
  logic                        fire;
  logic [2*NUM_REQUESTERS-1:0] req_twice;
  logic [NUM_REQUESTERS-1:0]   req_rot;
  logic [3:0]                  win_sum;
  logic [2:0]                  win_idx;
  logic [2:0]                  next_ptr;

  always_comb begin
    owner_req  = 1'b0;
    owner_tail = 1'b0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (out_sel_q == 3'(i)) begin
        owner_req  = bus.req[i];
        owner_tail = bus.tail[i];
      end
    end
  end

  // A flush cancels any transfer in the cycle it is asserted.
  assign fire = (state_q == LOCKED) && owner_req && (credits_q != '0) && !bus.flush;

  // Rotating the doubled request vector by ptr turns the round-robin search
  // into a plain lowest-set-bit search.
  always_comb begin
    req_twice = {bus.req, bus.req};
    req_rot   = NUM_REQUESTERS'(req_twice >> ptr_q);
    win_sum   = {1'b0, ptr_q};
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      if (req_rot[k]) win_sum = {1'b0, ptr_q} + 4'(k);
    end
    if (win_sum >= 4'(NUM_REQUESTERS)) win_sum = win_sum - 4'(NUM_REQUESTERS);
    win_idx  = win_sum[2:0];
    next_ptr = (out_sel_q == LAST_IDX) ? 3'd0 : out_sel_q + 3'd1;
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    out_sel_d = out_sel_q;
    ptr_d     = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.req != '0) begin
          state_d   = LOCKED;
          out_sel_d = win_idx;
          for (int i = 0; i < NUM_REQUESTERS; i++) gnt_d[i] = (win_idx == 3'(i));
        end
      end
      LOCKED: begin
        if (bus.flush || (fire && owner_tail)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          out_sel_d = 3'd0;
          ptr_d     = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A returned credit with nothing outstanding is an overflow: hold and flag.
  always_comb begin
    credits_d  = credits_q;
    cred_err_d = cred_err_q;
    if (fire && !bus.credit_in) begin
      credits_d = credits_q - 1'b1;
    end else if (bus.credit_in && !fire) begin
      if (credits_q == CREDIT_MAX_C) cred_err_d = 1'b1;
      else                           credits_d  = credits_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      out_sel_q  <= 3'd0;
      ptr_q      <= 3'd0;
      credits_q  <= CREDIT_MAX_C;
      cred_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      out_sel_q  <= out_sel_d;
      ptr_q      <= ptr_d;
      credits_q  <= credits_d;
      cred_err_q <= cred_err_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.out_sel  = out_sel_q;
  assign bus.busy     = (state_q == LOCKED);
  assign bus.fire     = fire;
  assign bus.credits  = credits_q;
  assign bus.cred_err = cred_err_q;
endmodule

// File: tb/tb_pkg_out_sched5.sv
// Self-checking bench for pkg_out_sched5: directed scenarios with literal
// expectations, then randomized traffic against a behavioural scheduler model.
module tb_pkg_out_sched5;
  logic clk;
  logic rst;

  pkg_out_sched5_if #(.NUM_REQUESTERS(5), .CW(3)) bus ();

  pkg_out_sched5 #(.NUM_REQUESTERS(5), .CREDIT_MAX(4), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: owner is -1 when no packet holds the output.
  int m_owner   = -1;
  int m_ptr     = 0;
  int m_credits = 4;
  int m_err     = 0;
  int m_fire    = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int predictFire(input logic [4:0] r, input logic f);
    if (m_owner < 0 || f) return 0;
    if (!r[m_owner] || m_credits == 0) return 0;
    return 1;
  endfunction

  // Drive inputs mid-cycle, then compare every DUT output against the model.
  task automatic applyStimulus(input logic [4:0] r, input logic [4:0] t,
                               input logic ci, input logic f, input logic rs);
    @(negedge clk);
    bus.req       = r;
    bus.tail      = t;
    bus.credit_in = ci;
    bus.flush     = f;
    rst           = rs;
    #1;
    m_fire = predictFire(r, f);
    checkOutput("gnt",      int'(bus.gnt),      (m_owner >= 0) ? (1 << m_owner) : 0);
    checkOutput("out_sel",  int'(bus.out_sel),  (m_owner >= 0) ? m_owner : 0);
    checkOutput("busy",     int'(bus.busy),     (m_owner >= 0) ? 1 : 0);
    checkOutput("fire",     int'(bus.fire),     m_fire);
    checkOutput("credits",  int'(bus.credits),  m_credits);
    checkOutput("cred_err", int'(bus.cred_err), m_err);
  endtask

  // Clock edge: advance the model from the inputs held across it.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_credits = 4; m_err = 0;
    end else begin
      if (m_owner < 0) begin
        for (int k = 0; k < 5; k++) begin
          int c;
          c = (m_ptr + k) % 5;
          if (bus.req[c]) begin
            m_owner = c;
            break;
          end
        end
      end else if (bus.flush || (m_fire == 1 && bus.tail[m_owner])) begin
        m_ptr   = (m_owner + 1) % 5;
        m_owner = -1;
      end
      if (m_fire == 1 && !bus.credit_in) m_credits--;
      else if (bus.credit_in && m_fire == 0) begin
        if (m_credits == 4) m_err = 1;
        else                m_credits++;
      end
    end
  endtask

  task automatic step(input logic [4:0] r, input logic [4:0] t,
                      input logic ci, input logic f, input logic rs);
    applyStimulus(r, t, ci, f, rs);
    advance();
  endtask

  initial begin
    int fires;
    int sent;
    bus.req = '0; bus.tail = '0; bus.credit_in = 1'b0; bus.flush = 1'b0; rst = 1'b1;

    // Single-flit packet on input 2.
    step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'b00100, 5'b00100, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_gnt", int'(bus.gnt), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_credits", int'(bus.credits), 4);
    checkOutput("rst_fire", int'(bus.fire), 0);
    checkOutput("rst_cred_err", int'(bus.cred_err), 0);
    advance();
    applyStimulus(5'b00100, 5'b00100, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_gnt", int'(bus.gnt), 5'b00100);
    checkOutput("t1_out_sel", int'(bus.out_sel), 2);
    checkOutput("t1_fire", int'(bus.fire), 1);
    advance();
    applyStimulus(5'b11111, 5'b11111, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_busy_after", int'(bus.busy), 0);
    checkOutput("t1_credits_after", int'(bus.credits), 3);
    advance();
    applyStimulus(5'b11111, 5'b11111, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_ptr3_gnt", int'(bus.gnt), 5'b01000);
    advance();

    // Round robin with credits returned on every fire.
    step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(5'b11111, 5'b11111, 1'(predictFire(5'b11111, 1'b0)), 1'b0, 1'b0);
      if (i % 2 == 1) checkOutput("rr_gnt", int'(bus.gnt), 1 << (((i - 1) / 2) % 5));
      else            checkOutput("rr_idle", int'(bus.busy), 0);
      checkOutput("rr_credits", int'(bus.credits), 4);
      advance();
    end

    // Three-flit packet on input 1 while input 3 also requests.
    step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    step(5'b01010, 5'b00000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(5'b01010, (i == 2) ? 5'b00010 : 5'b00000, 1'b0, 1'b0, 1'b0);
      checkOutput("lock_gnt", int'(bus.gnt), 5'b00010);
      checkOutput("lock_fire", int'(bus.fire), 1);
      advance();
    end
    step(5'b01000, 5'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(5'b01000, 5'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("lock_next_gnt", int'(bus.gnt), 5'b01000);
    advance();

    // Credit stall on a 6-flit packet from input 0.
    step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    fires = 0;
    sent  = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(5'b00001, (sent == 5) ? 5'b00001 : 5'b0, 1'b0, 1'b0, 1'b0);
      if (bus.fire) fires++;
      sent += m_fire;
      advance();
    end
    checkOutput("stall_fires", fires, 4);
    applyStimulus(5'b00001, 5'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("stall_credits", int'(bus.credits), 0);
    checkOutput("stall_fire", int'(bus.fire), 0);
    advance();
    applyStimulus(5'b00001, 5'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_resume_fire", int'(bus.fire), 1);
    advance();
    applyStimulus(5'b00001, 5'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("stall_again", int'(bus.fire), 0);
    advance();

    // Credit overflow and fire with simultaneous credit return.
    step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    step(5'b0, 5'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(5'b10000, 5'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_credits", int'(bus.credits), 4);
    checkOutput("ovf_err", int'(bus.cred_err), 1);
    advance();
    applyStimulus(5'b10000, 5'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("both_fire", int'(bus.fire), 1);
    advance();
    applyStimulus(5'b10000, 5'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("both_credits", int'(bus.credits), 4);
    checkOutput("err_sticky", int'(bus.cred_err), 1);
    advance();

    // Flush mid-packet on owner 4, then ptr wraps to 0.
    applyStimulus(5'b10000, 5'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_fire", int'(bus.fire), 0);
    advance();
    applyStimulus(5'b11111, 5'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_busy", int'(bus.busy), 0);
    advance();
    applyStimulus(5'b11111, 5'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("flush_ptr_gnt", int'(bus.gnt), 5'b00001);
    advance();

    // Reset mid-packet on owner 2.
    step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
    step(5'b00100, 5'b0, 1'b0, 1'b0, 1'b0);
    step(5'b00100, 5'b0, 1'b1, 1'b0, 1'b0);
    step(5'b00100, 5'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_rst_gnt", int'(bus.gnt), 0);
    checkOutput("mid_rst_busy", int'(bus.busy), 0);
    checkOutput("mid_rst_credits", int'(bus.credits), 4);
    checkOutput("mid_rst_err", int'(bus.cred_err), 0);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] r;
      logic [4:0] t;
      r = 5'($urandom_range(0, 31));
      t = 5'($urandom_range(0, 31));
      step(r, t, 1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 4),
           1'($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pkg_out_sched5.md
# pkg_out_sched5

Output-port packet scheduler for the 5-port router: one instance per output port. It arbitrates round-robin among the 5 input ports whose head flit targets this output. It locks the winner until that packet's tail flit has been transferred. It gates every flit transfer on a credit counter that tracks free slots in the downstream input buffer.

## Interface
- `NUM_REQUESTERS`, default 5: number of input ports. The logic is fixed to 5; the parameter exists for port sizing only.
- `CREDIT_MAX`, default 4: downstream buffer depth, which is also the reset value of the credit counter.
- `CW`, default 3: credit counter width. It must satisfy 2^CW > CREDIT_MAX.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset. It is sampled on the `clk` rising edge.
- `req` input 5: bit i = input i holds a valid flit destined for this output.
- `tail` input 5: bit i = the flit at input i is the last flit of its packet. It is only meaningful when `req[i]=1`.
- `credit_in` input 1: a one-cycle pulse meaning the downstream buffer freed one slot.
- `flush` input 1: abort the current packet lock.
- `gnt` output 5: one-hot registered owner. It is all-zero when idle.
- `out_sel` output 3: binary index of the owner, driving the crossbar mux select. It is 0 when idle.
- `busy` output 1: registered, 1 while a packet holds the lock.
- `fire` output 1: combinational, 1 when a flit moves this cycle.
- `credits` output CW: the current credit count.
- `cred_err` output 1: sticky flag set when a credit overflow occurs.

## Operation
State machine with two states, IDLE and LOCKED.

IDLE:
- When `req` is nonzero, pick the first set bit searching ptr, ptr+1, …, wrapping at 4 back to 0.
- Register the winner into `gnt`/`out_sel` and go to LOCKED.
- Arbitration ignores `credits`; flits simply wait in LOCKED until a credit is available.
- `fire` is always 0 in IDLE.

LOCKED:
- `fire = req[out_sel] & (credits != 0)`.
- `req` bits from non-owners are ignored.
- If the owner deasserts `req`, the lock holds and the packet stalls; this is not a release.
- A fire with `tail[out_sel]=1` releases the lock: next state is IDLE, `gnt`/`out_sel`/`busy` clear, and ptr becomes (owner+1) mod 5.
- `flush=1` releases the lock with the same ptr update. `fire` is forced to 0 in that cycle, and a flush has no effect in IDLE.

Round-robin pointer (ptr):
- 3 bits, reset value 0, values 0..4 only.
- It changes only on a release (tail fire or flush).

Credit counter:
- Reset value is CREDIT_MAX.
- `fire` & !`credit_in`: decrement by 1.
- `credit_in` & !`fire`: increment by 1.
- Both asserted together: unchanged.
- `credit_in` while `credits == CREDIT_MAX` and no fire: the counter holds at CREDIT_MAX and `cred_err` sets.
- Underflow cannot occur, because `fire` requires `credits != 0`.

`cred_err` is cleared only by `rst`.

## Timing
Reset values of every output: `gnt = 0`, `out_sel = 0`, `busy = 0`, `fire = 0`, `credits = CREDIT_MAX`, `cred_err = 0`. Internally, ptr = 0 and state = IDLE.

Reset mid-packet:
- The lock is dropped and all of the above values apply from the cycle after the `rst` edge.
- No tail is needed to recover.

Latency:
- `req` seen in IDLE at cycle t → `gnt`/`busy` valid at t+1 → earliest `fire` at t+1.
- Every packet pays exactly one arbitration bubble after the previous release.
- A single-flit packet (head = tail): lock at t+1, fire plus release at t+1, IDLE at t+2, next arbitration at t+2, next fire at t+3.
- Steady-state throughput inside a packet is 1 flit per cycle while credits stay above 0.

`fire` and the credit decrement take effect in the same cycle. The flit is consumed by the downstream register on the same edge.

`flush` and a tail fire in the same cycle: flush wins. `fire` = 0 and ptr advances once.

## Test plan
1. Reset, then `req = 5'b00100`, `tail = 5'b00100` for one cycle: `gnt = 00100`, `out_sel = 2` and `fire = 1` one cycle later. Then `busy = 0`, `credits = 3`, ptr = 3.
2. Round robin: hold `req = 5'b11111` with every flit a tail, and pulse `credit_in` on each fire. Grant order is 0, 1, 2, 3, 4, 0. There is one idle cycle between grants and `credits` stays at 4.
3. Packet lock: input 1 sends a 3-flit packet (tail on flit 3) while `req[3]` stays high. `gnt` stays 00010 for all 3 fires, and input 3 is granted only after the release.
4. Credit stall: with `credit_in` tied to 0, send a 6-flit packet on input 0. `fire` occurs 4 times, then `credits = 0` and `fire = 0`. A `credit_in` pulse gives exactly 1 more fire next cycle.
5. Simultaneous fire and `credit_in` keeps `credits` constant. With `credits = 4`, a `credit_in` pulse and no fire leaves `credits = 4` and sets `cred_err = 1`, which persists until `rst`.
6. A `flush` mid-packet on owner 4 gives `busy = 0` next cycle, `fire = 0` in the flush cycle, and ptr = 0. Asserting `rst` mid-packet on owner 2 returns all outputs to reset values the next cycle.
